unit_prop_ctrl: RTL
===================

UNIT_PROP_CTRL -- requirements
Module: unit_prop_ctrl

Interface
REQ-001 SHALL have parameter NV, default 7, meaning number of variables; variable index 0 is reserved as the empty/padding literal.
REQ-002 SHALL have parameter VW, default 3, meaning variable-index width; a literal is {var[VW-1:0], pol}, and pol=1 means positive.
REQ-003 Ports, in order:
- clock  in  1  system clock; rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin one propagation run.
- clear  in  1  clear assignment state.
- uc_find  out  1  search request to the unit-clause engine.
- uc_ended  in  1  engine search-complete pulse.
- uc_found  in  1  a unit clause exists; valid with uc_ended.
- uc_lit  in  VW+1  the unit literal; valid with uc_ended.
- simp_req  out  1  simplify-formula request.
- simp_lit  out  VW+1  literal being applied.
- simp_ack  in  1  simplifier done.
- simp_conflict  in  1  simplifier produced an empty clause; valid with simp_ack.
- assign_val  out  NV+1  value per variable; bit 0 unused.
- assign_mask  out  NV+1  1 = variable assigned; bit 0 is always 0.
- prop_count  out  VW+1  literals propagated in the current run.
- busy  out  1  a run is in progress.
- done  out  1  run ended with no further unit clause.
- conflict  out  1  run ended in a conflict.
- err  out  1  protocol error.
- trail_idx  in  VW  trail read index.
- trail_lit  out  VW+1  trail read data.

Function
REQ-004 SHALL implement the FSM states IDLE, FIND, WAIT_UC, CHECK, SIMP, FIN.
REQ-005 IDLE/FIN: start=1 SHALL go to FIND next cycle, clear prop_count/done/conflict/err, and set busy; start SHALL be ignored while busy.
REQ-006 FIND SHALL assert uc_find for exactly one cycle, then go to WAIT_UC; uc_find SHALL be 0 in every other state.
REQ-007 WAIT_UC SHALL hold until uc_ended=1, latch uc_found/uc_lit, then go to CHECK; a uc_ended in any other state SHALL be ignored.
REQ-008 CHECK, uc_found=0: SHALL go to FIN with done=1.
REQ-009 CHECK, found literal has var=0: SHALL go to FIN with err=1 and conflict=1.
REQ-010 CHECK, var already assigned with opposite polarity: SHALL go to FIN with conflict=1.
REQ-011 CHECK, var already assigned with the same polarity: SHALL go to FIN with err=1.
REQ-012 CHECK, var unassigned: SHALL set assign_mask[var]=1 and assign_val[var]=pol in the same cycle, increment prop_count, and go to SIMP.
REQ-013 SIMP SHALL hold simp_req=1 and simp_lit stable until simp_ack=1.
REQ-014 On simp_ack: simp_conflict=1 SHALL go to FIN with conflict=1; otherwise SHALL go to FIND.
REQ-015 simp_ack arriving in the same cycle simp_req first rises SHALL be accepted.
REQ-016 prop_count SHALL NOT exceed NV; CHECK reached with prop_count=NV and uc_found=1 SHALL go to FIN with err=1.
REQ-017 done, conflict and err SHALL hold in FIN until the next start; busy=0 in IDLE and FIN only.
REQ-018 clear SHALL zero assign_val/assign_mask in IDLE/FIN, SHALL be ignored while busy, and when coincident with start SHALL clear first and then begin the run.
REQ-019 Worst-case latency per propagated literal SHALL be 3 cycles plus engine and simplifier latency.

Reset
REQ-020 reset=1 SHALL asynchronously force IDLE and drive all outputs and registers to 0, including trail entries.
REQ-021 reset asserted mid-run SHALL abandon any outstanding uc/simp handshake; an uc_ended or simp_ack arriving after reset release SHALL be ignored in IDLE.

Configuration
REQ-022 With UP_TRAIL_EN defined, SHALL record each literal accepted in CHECK at trail entry prop_count (pre-increment).
REQ-023 With UP_TRAIL_EN defined, trail_lit SHALL equal entry trail_idx combinationally; start SHALL NOT clear the trail, clear SHALL.
REQ-024 Without UP_TRAIL_EN, no trail storage SHALL exist and trail_lit SHALL be constant 0.

Verification
REQ-025 start; engine returns found {3,0}, simplifier ack; then engine returns found=0 -> assign_mask=0x08, assign_val=0x00, prop_count=1, done=1.
REQ-026 Engine returns {2,1} then {5,0}, then none -> mask=0x24, val=0x04, prop_count=2; with UP_TRAIL_EN, trail[0]={2,1} and trail[1]={5,0}.
REQ-027 Engine returns {1,1}; simp_ack with simp_conflict=1 -> conflict=1, done=0, prop_count=1.
REQ-028 Engine returns {4,1} then {4,0} -> conflict=1 with no second simp_req; the same-polarity variant -> err=1.
REQ-029 Engine returns found with {0,1} -> err=1, conflict=1; separately, reset asserted during SIMP -> all outputs 0 within the same cycle, and a later simp_ack is ignored.
REQ-030 start while busy, and clear while busy -> no effect; clear and start together in FIN -> mask=0 before the first uc_find.

Source files
------------

// File: rtl/unit_prop_ctrl.sv
// Unit-propagation sequencer: pulls unit literals from an external engine, records assignments
// and hands each new literal to the simplifier. Build option UP_TRAIL_EN adds a readable literal trail.
module unit_prop_ctrl #(
    parameter int NV = 7,
    parameter int VW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    output logic          uc_find,
    input  logic          uc_ended,
    input  logic          uc_found,
    input  logic [VW:0]   uc_lit,
    output logic          simp_req,
    output logic [VW:0]   simp_lit,
    input  logic          simp_ack,
    input  logic          simp_conflict,
    output logic [NV:0]   assign_val,
    output logic [NV:0]   assign_mask,
    output logic [VW:0]   prop_count,
    output logic          busy,
    output logic          done,
    output logic          conflict,
    output logic          err,
    input  logic [VW-1:0] trail_idx,
    output logic [VW:0]   trail_lit
);
    // state   | meaning
    // IDLE    | after reset, waiting for start
    // FIND    | one-cycle search request to the engine
    // WAIT_UC | waiting for the engine result
    // CHECK   | classify the returned literal against the assignment
    // SIMP    | simplifier handshake for the accepted literal
    // FIN     | run ended, status flags held until next start
    typedef enum logic [2:0] {S_IDLE, S_FIND, S_WAIT_UC, S_CHECK, S_SIMP, S_FIN} state_t;

    localparam logic [VW:0] NV_CNT = (VW+1)'(NV);

    state_t        r_state, w_next;
    logic [NV:0]   r_val, r_mask;
    logic [VW:0]   r_count, r_lit;
    logic          r_found, r_done, r_conflict, r_err;

    logic [VW-1:0] w_var;
    logic          w_pol, w_assigned, w_cur, w_idle;
    logic          w_ck_zero, w_ck_full, w_ck_opp, w_ck_same, w_ck_new;

    assign w_var      = r_lit[VW:1];
    assign w_pol      = r_lit[0];
    assign w_assigned = r_mask[w_var];
    assign w_cur      = r_val[w_var];
    assign w_idle     = (r_state == S_IDLE) || (r_state == S_FIN);

    assign w_ck_zero = r_found && (w_var == '0);
    assign w_ck_full = r_found && !w_ck_zero && (r_count == NV_CNT);
    assign w_ck_opp  = r_found && !w_ck_zero && !w_ck_full && w_assigned && (w_cur != w_pol);
    assign w_ck_same = r_found && !w_ck_zero && !w_ck_full && w_assigned && (w_cur == w_pol);
    assign w_ck_new  = r_found && !w_ck_zero && !w_ck_full && !w_assigned;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        uc_find  = 1'b0;
        simp_req = 1'b0;
        simp_lit = '0;
        busy     = 1'b1;
        case (r_state)
            S_IDLE, S_FIN: begin
                busy = 1'b0;
                if (start) w_next = S_FIND;
            end
            S_FIND: begin
                uc_find = 1'b1;
                w_next  = S_WAIT_UC;
            end
            S_WAIT_UC: if (uc_ended) w_next = S_CHECK;
            S_CHECK:   w_next = w_ck_new ? S_SIMP : S_FIN;
            S_SIMP: begin
                simp_req = 1'b1;
                simp_lit = r_lit;
                if (simp_ack) w_next = simp_conflict ? S_FIN : S_FIND;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_val      <= '0;
            r_mask     <= '0;
            r_count    <= '0;
            r_lit      <= '0;
            r_found    <= 1'b0;
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    // clear and start in the same cycle: both take effect, run starts on a clean slate
                    if (clear) begin
                        r_val  <= '0;
                        r_mask <= '0;
                    end
                    if (start) begin
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_conflict <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                S_WAIT_UC: if (uc_ended) begin
                    r_found <= uc_found;
                    r_lit   <= uc_lit;
                end
                S_CHECK: begin
                    r_done     <= !r_found;
                    r_err      <= w_ck_zero || w_ck_full || w_ck_same;
                    r_conflict <= w_ck_zero || w_ck_opp;
                    if (w_ck_new) begin
                        r_mask[w_var] <= 1'b1;
                        r_val[w_var]  <= w_pol;
                        r_count       <= r_count + {{VW{1'b0}}, 1'b1};
                    end
                end
                S_SIMP: if (simp_ack && simp_conflict) r_conflict <= 1'b1;
                default: ;
            endcase
        end
    end

    assign assign_val  = r_val;
    assign assign_mask = r_mask;
    assign prop_count  = r_count;
    assign done        = r_done;
    assign conflict    = r_conflict;
    assign err         = r_err;

`ifdef UP_TRAIL_EN
    logic [VW:0] r_trail [0:(1<<VW)-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < (1<<VW); i++) r_trail[i] <= '0;
        end else if (w_idle && clear) begin
            for (int i = 0; i < (1<<VW); i++) r_trail[i] <= '0;
        end else if ((r_state == S_CHECK) && w_ck_new) begin
            r_trail[r_count[VW-1:0]] <= r_lit;
        end
    end

    assign trail_lit = r_trail[trail_idx];
`else
    logic w_unused_trail;
    assign w_unused_trail = ^trail_idx;
    assign trail_lit      = '0;
`endif

endmodule
